led_bank_arbiter: RTL and testbench

LED_BANK_ARBITER -- requirements
Module: led_bank_arbiter

---
 rtl/led_bank_arbiter.sv | 145 ++++++++++++++
 tb/tb_led_bank_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of a shared LED bank with a minimum hold time and a contended-grant timeout.
// Latency: request to o_gnt 1 cycle; o_led_l follows o_gnt 1 cycle later. Back-pressure: a requester just holds i_req until granted.
module led_bank_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int LED_W          = 8,
    parameter int HOLD_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ*LED_W-1:0]   i_pattern,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [LED_W-1:0]           o_led_l,
    output logic                       o_busy,
    output logic                       o_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_RELEASE
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [LED_W-1:0]   led_l_q, led_l_d;
    logic               timeout_q, timeout_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W:0]     cand;
    logic [IDX_W:0]     owner_inc;
    logic               owner_req;
    logic               others_req;

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(i);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!win_found && i_req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        owner_inc = {1'b0, owner_q} + (IDX_W + 1)'(1);
        if (owner_inc >= NUM_REQ_W) begin
            owner_inc = '0;
        end
    end

    // gnt_q is one-hot on the owner while in OWN, so it masks the owner out.
    assign owner_req  = i_req[owner_q];
    assign others_req = |(i_req & ~gnt_q);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        timeout_d  = 1'b0;
        led_l_d    = '1;
        if (state_q == ST_OWN) begin
            led_l_d = ~i_pattern[int'(owner_q) * LED_W +: LED_W];
        end

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d        = ST_OWN;
                    owner_d        = win_idx;
                    hold_cnt_d     = '0;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                end
            end
            ST_OWN: begin
                if (hold_cnt_q != CNT_MAX) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
                if ((hold_cnt_q >= HOLD_LAST) && !owner_req) begin
                    state_d = ST_RELEASE;
                    gnt_d   = '0;
                end else if (owner_req && (hold_cnt_q == CNT_MAX) && others_req) begin
                    state_d   = ST_RELEASE;
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d  = ST_IDLE;
                rr_ptr_d = owner_inc[IDX_W-1:0];
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            led_l_q    <= '1;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            led_l_q    <= led_l_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_gnt     = gnt_q;
    assign o_led_l   = led_l_q;
    assign o_busy    = (state_q == ST_OWN);
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter: a cycle model predicts outputs into a scoreboard,
// plus targeted checks of hold length, round-robin order, wrap, saturation, isolation and async reset.
module tb_led_bank_arbiter;

    localparam int NR = 4;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req;
    logic [31:0]   pat;
    logic [NR-1:0] o_gnt;
    logic [LW-1:0] o_led_l;
    logic          o_busy;
    logic          o_timeout;

    always #5 clk = ~clk;

    led_bank_arbiter #(
        .NUM_REQ        (NR),
        .LED_W          (LW),
        .HOLD_CYCLES    (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_pattern (pat),
        .o_gnt     (o_gnt),
        .o_led_l   (o_led_l),
        .o_busy    (o_busy),
        .o_timeout (o_timeout)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] led;
        logic       busy;
        logic       tmo;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state: 0 idle, 1 own, 2 release
    int m_state, m_owner, m_rr, m_hold;

    logic [3:0] prev_gnt;
    int         owners[$];
    int         tmo_cnt;
    int         gcnt[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_owner  = 0;
        m_rr     = 0;
        m_hold   = 0;
        prev_gnt = '0;
        sb.delete();
    endtask

    task automatic clear_obs();
        owners.delete();
        tmo_cnt = 0;
        for (int k = 0; k < 4; k++) gcnt[k] = 0;
    endtask

    task automatic step(input logic [3:0] r);
        exp_t e;
        exp_t got_e;
        logic found;
        int   k;
        logic others;
        req   = r;
        e.led = (m_state == 1) ? ~pat[m_owner*8 +: 8] : 8'hFF;
        e.tmo = 1'b0;
        case (m_state)
            0: begin
                if (r != 4'b0) begin
                    found = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        k = (m_rr + i) % 4;
                        if (!found && r[k]) begin
                            found   = 1'b1;
                            m_owner = k;
                        end
                    end
                    m_state = 1;
                    m_hold  = 0;
                end
            end
            1: begin
                others = |(r & ~(4'b0001 << m_owner));
                if (m_hold >= 3 && !r[m_owner]) begin
                    m_state = 2;
                end else if (r[m_owner] && m_hold == 15 && others) begin
                    m_state = 2;
                    e.tmo   = 1'b1;
                end
                if (m_hold < 15) m_hold = m_hold + 1;
            end
            default: begin
                m_state = 0;
                m_rr    = (m_owner + 1) % 4;
            end
        endcase
        e.gnt  = (m_state == 1) ? (4'b0001 << m_owner) : 4'b0000;
        e.busy = (m_state == 1);
        sb.push_back(e);

        @(posedge clk);
        #1;
        got_e = sb.pop_front();
        chk("gnt", 32'(o_gnt), 32'(got_e.gnt));
        chk("led", 32'(o_led_l), 32'(got_e.led));
        chk("busy", 32'(o_busy), 32'(got_e.busy));
        chk("tmo", 32'(o_timeout), 32'(got_e.tmo));
        chk("onehot", 32'($onehot0(o_gnt)), 32'(1));

        if (o_gnt != 4'b0 && prev_gnt == 4'b0) begin
            for (int j = 0; j < 4; j++) if (o_gnt[j]) owners.push_back(j);
        end
        for (int j = 0; j < 4; j++) if (o_gnt[j]) gcnt[j]++;
        if (o_timeout) tmo_cnt++;
        prev_gnt = o_gnt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(o_gnt), 32'h0);
        chk("rst_led", 32'(o_led_l), 32'hFF);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_tmo", 32'(o_timeout), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_own[5];
        exp_own = '{0, 1, 2, 3, 0};
        rst_n = 1'b1;
        req   = '0;
        pat   = '0;
        clear_obs();
        #2;
        do_reset();

        step(4'b0000);
        step(4'b0000);

        // Single requester with a one-cycle request
        clear_obs();
        pat = 32'h0000_0F00;
        step(4'b0010);
        chk("grant_latency", 32'(o_gnt), 32'h2);
        step(4'b0000);
        chk("led_on", 32'(o_led_l), 32'hF0);
        repeat (6) step(4'b0000);
        chk("hold_len", 32'(gcnt[1]), 32'd4);
        chk("led_off", 32'(o_led_l), 32'hFF);

        // Round-robin under full contention, released by timeout
        do_reset();
        clear_obs();
        pat = 32'h4433_2211;
        repeat (80) step(4'b1111);
        chk("rr_count", 32'(owners.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < owners.size()) chk("rr_owner", 32'(owners[i]), 32'(exp_own[i]));
        end
        chk("rr_tmo", 32'(tmo_cnt), 32'd4);
        chk("rr_len1", 32'(gcnt[1]), 32'd16);
        chk("rr_len2", 32'(gcnt[2]), 32'd16);
        chk("rr_len3", 32'(gcnt[3]), 32'd16);

        // Wrap: leave rr_ptr at 3, then request 0 and 2
        do_reset();
        step(4'b0100);
        repeat (5) step(4'b0000);
        step(4'b0101);
        chk("wrap", 32'(o_gnt), 32'h1);
        repeat (6) step(4'b0000);

        // Uncontended hold then late contention hits the saturated counter
        clear_obs();
        repeat (100) step(4'b0100);
        chk("unc_len", 32'(gcnt[2]), 32'd100);
        chk("unc_tmo", 32'(tmo_cnt), 32'd0);
        chk("unc_gnt", 32'(o_gnt), 32'h4);
        step(4'b0101);
        chk("sat_tmo", 32'(o_timeout), 32'h1);
        chk("sat_gnt", 32'(o_gnt), 32'h0);
        repeat (3) step(4'b0000);

        // Isolation: toggle a non-owner pattern every cycle
        pat = 32'h0000_A500;
        step(4'b0010);
        for (int i = 0; i < 10; i++) begin
            pat[31:24] = ~pat[31:24];
            step(4'b0010);
            chk("iso_led", 32'(o_led_l), 32'h5A);
        end
        repeat (6) step(4'b0000);

        // Asynchronous reset while requester 2 owns
        pat[23:16] = 8'h3C;
        step(4'b0100);
        step(4'b0100);
        chk("pre_rst_gnt", 32'(o_gnt), 32'h4);
        chk("pre_rst_led", 32'(o_led_l), 32'hC3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(o_gnt), 32'h0);
        chk("arst_led", 32'(o_led_l), 32'hFF);
        chk("arst_busy", 32'(o_busy), 32'h0);
        chk("arst_tmo", 32'(o_timeout), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b1111);
        chk("restart_idx0", 32'(o_gnt), 32'h1);
        step(4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
